cache_data_array: RTL

CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_refill_ctrl.sv | 104 ++++++++++
 rtl/cache_data_array.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache data array slice.
//   DefSets/DefWays/DefWords : default geometry of the data array
//   refill_state_e           : refill controller state encoding
package cache_pkg;

  localparam int unsigned DefSets  = 256;
  localparam int unsigned DefWays  = 2;
  localparam int unsigned DefWords = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line refill controller: tracks one refill at a time, starting at the
// critical word and wrapping through the line.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   rf_start/index/way/offset : refill request (accepted only when idle)
//   rf_valid, rf_ready      : beat handshake
//   rf_busy, rf_done        : refill in progress / one-cycle completion pulse
//   fill_active             : controller is accepting beats
//   fill_we                 : write the current beat this cycle
//   fill_index/way/ptr      : array location for the current beat
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned WAY_W = 1,
  parameter int unsigned OFF_W = 2,
  parameter int unsigned WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rf_start,
  input  logic [IDX_W-1:0] rf_index,
  input  logic [WAY_W-1:0] rf_way,
  input  logic [OFF_W-1:0] rf_offset,
  input  logic             rf_valid,
  output logic             rf_ready,
  output logic             rf_busy,
  output logic             rf_done,
  output logic             fill_active,
  output logic             fill_we,
  output logic [IDX_W-1:0] fill_index,
  output logic [WAY_W-1:0] fill_way,
  output logic [OFF_W-1:0] fill_ptr
);

  refill_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [OFF_W-1:0] ptr_q, ptr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    way_d   = way_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (rf_start) begin
          idx_d   = rf_index;
          way_d   = rf_way;
          ptr_d   = rf_offset;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (rf_valid) begin
          // Pointer width equals log2(WORDS), so the increment wraps naturally.
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      way_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fill_active = (state_q == StFill);
    rf_ready    = fill_active;
    rf_busy     = (state_q != StIdle);
    rf_done     = (state_q == StDone);
    fill_we     = fill_active && rf_valid && !reset;
    fill_index  = idx_q;
    fill_way    = way_q;
    fill_ptr    = ptr_q;
  end

endmodule

// File: rtl/cache_data_array.sv
// Set-associative cache data array with a registered full-set read port,
// byte-masked store port and a wrapping line-refill port.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   rd_req, rd_index          : read all ways of a set
//   rd_line, rd_valid         : registered set contents, one-cycle valid pulse
//   wr_req/index/way/offset/wstrb/data, wr_ready : byte-masked word store
//   rf_start/index/way/offset : begin refill at the critical word
//   rf_valid, rf_data, rf_ready : refill beats
//   rf_busy, rf_done          : refill status
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS  = DefSets,
  parameter int unsigned WAYS  = DefWays,
  parameter int unsigned WORDS = DefWords,
  localparam int unsigned IDX_W  = $clog2(SETS),
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned OFF_W  = $clog2(WORDS),
  localparam int unsigned LINE_W = WAYS * WORDS * 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [LINE_W-1:0] rd_line,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WAY_W-1:0]  wr_way,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [3:0]        wr_wstrb,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  input  logic              rf_start,
  input  logic [IDX_W-1:0]  rf_index,
  input  logic [WAY_W-1:0]  rf_way,
  input  logic [OFF_W-1:0]  rf_offset,
  input  logic              rf_valid,
  input  logic [31:0]       rf_data,
  output logic              rf_ready,
  output logic              rf_busy,
  output logic              rf_done
);

  logic [31:0] mem [SETS][WAYS][WORDS];

  logic              fill_active;
  logic              fill_we;
  logic [IDX_W-1:0]  fill_index;
  logic [WAY_W-1:0]  fill_way;
  logic [OFF_W-1:0]  fill_ptr;
  logic              st_we;
  logic [LINE_W-1:0] rd_line_d, rd_line_q;
  logic              rd_valid_q;

  cache_refill_ctrl #(
    .IDX_W (IDX_W),
    .WAY_W (WAY_W),
    .OFF_W (OFF_W),
    .WORDS (WORDS)
  ) u_refill_ctrl (
    .clk         (clk),
    .reset       (reset),
    .rf_start    (rf_start),
    .rf_index    (rf_index),
    .rf_way      (rf_way),
    .rf_offset   (rf_offset),
    .rf_valid    (rf_valid),
    .rf_ready    (rf_ready),
    .rf_busy     (rf_busy),
    .rf_done     (rf_done),
    .fill_active (fill_active),
    .fill_we     (fill_we),
    .fill_index  (fill_index),
    .fill_way    (fill_way),
    .fill_ptr    (fill_ptr)
  );

  // Stores to the line being refilled are held off so a beat never lands on
  // top of newer store data.
  always_comb begin
    wr_ready = !(fill_active && (wr_index == fill_index) && (wr_way == fill_way));
    st_we    = wr_req && wr_ready && !reset;
  end

  always_ff @(posedge clk) begin
    if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_wstrb[b]) begin
          mem[wr_index][wr_way][wr_offset][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (fill_we) begin
      mem[fill_index][fill_way][fill_ptr] <= rf_data;
    end
  end

  // Write-first read: same-edge store bytes and refill beats are merged into
  // the captured line. A store and a beat never hit the same word because the
  // store is blocked for the refilling way.
  always_comb begin
    logic [31:0] word;
    rd_line_d = '0;
    word      = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < WORDS; k++) begin
        word = mem[rd_index][w][k];
        if (st_we && (wr_index == rd_index) && (wr_way == WAY_W'(w)) &&
            (wr_offset == OFF_W'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_wstrb[b]) begin
              word[8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end
        if (fill_we && (fill_index == rd_index) && (fill_way == WAY_W'(w)) &&
            (fill_ptr == OFF_W'(k))) begin
          word = rf_data;
        end
        rd_line_d[(w*WORDS+k)*32 +: 32] = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_line_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_line_q <= rd_line_d;
      end
    end
  end

  assign rd_line  = rd_line_q;
  assign rd_valid = rd_valid_q;

endmodule
